// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, serial line levels and parity type codes.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register (LSB out first) with a data-bit counter and last-bit flag.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic                  cnt_clr,
    output logic                  bit_c,
    output logic                  done_c
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]      cnt;

    // Clear has priority so the counter starts at 0 on the cycle DATA is entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                shreg <= load_data;
            end else if (shift) begin
                shreg <= shreg >> 1;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (shift) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign bit_c  = shreg[0];
    assign done_c = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop; one bit per CLK.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    state_t state_q;
    state_t state_d;
    logic   tx_d;
    logic   busy_d;
    logic   load;
    logic   shift;
    logic   cnt_clr;
    logic   par_en_q;
    logic   par_q;
    logic   ser_bit_c;
    logic   ser_done_c;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .load_data (P_DATA),
        .shift     (shift),
        .cnt_clr   (cnt_clr),
        .bit_c     (ser_bit_c),
        .done_c    (ser_done_c)
    );

    // State, registered line outputs and the frame config latched at accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            TX_OUT   <= IDLE_LVL;
            Busy     <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            Busy    <= busy_d;
            if (load) begin
                par_en_q <= PAR_EN;
                par_q    <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
            end
        end
    end

    // tx_d/busy_d are the line values for the state being entered.
    always_comb begin
        state_d = state_q;
        tx_d    = IDLE_LVL;
        busy_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (Data_Valid) begin
                    state_d = START;
                    load    = 1'b1;
                    tx_d    = START_LVL;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                shift   = 1'b1;
                cnt_clr = 1'b1;
                tx_d    = ser_bit_c;
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (!ser_done_c) begin
                    shift = 1'b1;
                    tx_d  = ser_bit_c;
                end else if (par_en_q) begin
                    state_d = PARITY;
                    tx_d    = par_q;
                end else begin
                    state_d = STOP;
                    tx_d    = STOP_LVL;
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_LVL;
                busy_d  = 1'b1;
            end
            STOP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: framing, parity, back-to-back, reset abort, illegal-state recovery.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       dv;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int total;
    int bad;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .Data_Valid (dv),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .TX_OUT     (tx_out),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dv = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        tick();
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL reset: tx=%b busy=%b state=%0d, want tx=1 busy=0 state=0", tx_out, busy, dut.state_q);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset c%0d: tx=%b busy=%b, want tx=1 busy=0", i, tx_out, busy);
            end
        end
    endtask

    task automatic test_no_parity();
        logic [0:9] exp;
        exp = 10'b0101001011;
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        tick();
        dv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            total++;
            if (tx_out !== exp[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL no_parity c%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp[i]);
            end
        end
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL no_parity idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_parity();
        logic [7:0]  d [4];
        logic        t [4];
        logic [0:10] e [4];
        d = '{8'hA5, 8'hA5, 8'h00, 8'hFF};
        t = '{PAR_EVEN, PAR_ODD, PAR_ODD, PAR_EVEN};
        e = '{11'b01010010101, 11'b01010010111, 11'b00000000011, 11'b01111111101};
        for (int c = 0; c < 4; c++) begin
            p_data = d[c]; par_en = 1'b1; par_typ = t[c]; dv = 1'b1;
            tick();
            dv = 1'b0;
            par_en = 1'b0;
            for (int i = 0; i < 11; i++) begin
                if (i > 0) tick();
                total++;
                if (tx_out !== e[c][i] || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL parity case%0d c%0d: tx=%b busy=%b, want tx=%b busy=1", c, i, tx_out, busy, e[c][i]);
                end
            end
            tick();
            total++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL parity case%0d idle: tx=%b busy=%b, want tx=1 busy=0", c, tx_out, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:9] ea;
        logic [0:9] eb;
        ea = 10'b0001111001;
        eb = 10'b0110000111;
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            total++;
            if (tx_out !== ea[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b frameA c%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, ea[i]);
            end
            if (i == 2) p_data = 8'hC3;
        end
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b gap: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            total++;
            if (tx_out !== eb[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b frameB c%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, eb[i]);
            end
            if (i == 0) dv = 1'b0;
            if (i == 3) p_data = 8'hFF;
        end
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [0:9] exp;
        exp = 10'b0010110101;
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        tick();
        dv = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (tx_out !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL abort pre-reset bit4: tx=%b busy=%b, want tx=0 busy=1", tx_out, busy);
        end
        rst = 1'b1;
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL abort reset: tx=%b busy=%b state=%0d, want tx=1 busy=0 state=0", tx_out, busy, dut.state_q);
        end
        rst = 1'b0;
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort no_resume: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        p_data = 8'h5A; dv = 1'b1;
        tick();
        dv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            total++;
            if (tx_out !== exp[i] || busy !== 1'b1) begin
                bad++;
                $display("FAIL abort clean_frame c%0d: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp[i]);
            end
        end
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_illegal_state();
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; dv = 1'b1;
        tick();
        dv = 1'b0;
        force dut.state_q = state_t'(3'b111);
        #2;
        release dut.state_q;
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL illegal_state: tx=%b busy=%b state=%0d, want tx=1 busy=0 state=0", tx_out, busy, dut.state_q);
        end
        tick();
        total++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL illegal_state hold: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; dv = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        test_reset();
        test_no_parity();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_illegal_state();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
